// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and Q2.14 format constants for the sequenced MAC.
package mac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
  localparam int FRAC_W = 14;
  localparam int Q_W = 16;
  localparam logic [Q_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [Q_W-1:0] Q_MIN = 16'h8000;
endpackage

// File: rtl/q_narrow_sat.sv
// q_narrow_sat: narrows the signed accumulator to a Q2.14 word.
// MAC_SAT_EN selects clamping to [Q_MIN, Q_MAX]; otherwise the low 16 bits wrap.
module q_narrow_sat
  import mac_pkg::*;
#(
  parameter int ACC_W = 28
) (
  input  logic [ACC_W-1:0] acc,
  output logic [Q_W-1:0]   res
);
`ifdef MAC_SAT_EN
  logic [ACC_W-Q_W:0] hi;
  logic fits;
  assign hi = acc[ACC_W-1:Q_W-1];
  // the value fits when every bit above the Q2.14 sign bit matches it
  assign fits = (&hi) | ~(|hi);
  assign res = fits ? acc[Q_W-1:0] : (acc[ACC_W-1] ? Q_MIN : Q_MAX);
`else
  logic unused_hi;
  assign unused_hi = ^acc[ACC_W-1:Q_W];
  assign res = acc[Q_W-1:0];
`endif
endmodule

// File: rtl/mac_seq_q2_14.sv
// mac_seq_q2_14: bias-seeded Q2.14 dot product over N streamed operand pairs, one result per job.
// Build option: MAC_SAT_EN makes the final narrowing saturate instead of wrap.
module mac_seq_q2_14
  import mac_pkg::*;
#(
  parameter int LEN_W = 10,
  parameter int ACC_W = 28
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [15:0]      i_bias,
  input  logic             i_valid,
  input  logic [15:0]      i_a,
  input  logic [15:0]      i_b,
  output logic             o_ready,
  output logic             o_valid,
  output logic [15:0]      o_res,
  input  logic             i_res_ready,
  output logic             o_busy,
  output logic             o_done
);
  state_t state, nxt;
  logic [LEN_W-1:0] cnt, n_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [17:0] p_reg;
  logic p_vld;
  logic signed [31:0] prod;
  logic run_rdy, accept, last;
  logic [Q_W-1:0] narrowed;
  assign prod = $signed(i_a) * $signed(i_b);
  assign run_rdy = (state == RUN) && (cnt < n_reg);
  assign accept = i_valid & run_rdy;
  assign last = accept && (cnt + LEN_W'(1) == n_reg);
  q_narrow_sat #(.ACC_W(ACC_W)) u_narrow (
    .acc(acc),
    .res(narrowed)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    o_ready = run_rdy;
    o_valid = 1'b0;
    o_res = '0;
    o_busy = state != IDLE;
    o_done = 1'b0;
    unique case (state)
      IDLE: if (i_start) nxt = (i_len == '0) ? OUT : RUN;
      RUN: if (last) nxt = DRAIN;
      DRAIN: nxt = OUT;
      OUT: begin
        o_valid = 1'b1;
        o_res = narrowed;
        o_done = i_res_ready;
        if (i_res_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // products are registered, so the accumulator runs one cycle behind the accepts
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      n_reg <= '0;
      acc <= '0;
      p_reg <= '0;
      p_vld <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        p_reg <= 18'(prod >>> FRAC_W);
        cnt <= cnt + LEN_W'(1);
      end
      if (state == IDLE && i_start) begin
        n_reg <= i_len;
        cnt <= '0;
        acc <= ACC_W'($signed(i_bias));
      end else if (p_vld) begin
        acc <= acc + ACC_W'(p_reg);
      end
      if (state == OUT && i_res_ready) cnt <= '0;
    end
  end
endmodule

// File: tb/tb_mac_seq_q2_14.sv
// tb_mac_seq_q2_14: directed and random jobs against an arithmetic dot-product model.
module tb_mac_seq_q2_14;
  localparam int LEN_W = 10;
  localparam int ACC_W = 28;
  logic i_clk = 0, i_rst = 1, i_start = 0, i_valid = 0, i_res_ready = 0;
  logic [LEN_W-1:0] i_len = '0;
  logic [15:0] i_bias = '0, i_a = '0, i_b = '0;
  logic o_ready, o_valid, o_busy, o_done;
  logic [15:0] o_res;
  int checks = 0, fails = 0, cyc = 0, done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] da[1024];
  logic [15:0] db[1024];
  logic [15:0] r;

  mac_seq_q2_14 #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len), .i_bias(i_bias),
    .i_valid(i_valid), .i_a(i_a), .i_b(i_b), .o_ready(o_ready), .o_valid(o_valid),
    .o_res(o_res), .i_res_ready(i_res_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] model(logic [15:0] bias, int n);
    longint s;
    s = longint'($signed(bias));
    for (int k = 0; k < n; k++)
      s += (longint'($signed(da[k])) * longint'($signed(db[k]))) >>> 14;
`ifdef MAC_SAT_EN
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return 16'(s);
  endfunction

  always @(negedge i_clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", o_valid, 0);
      else check("o_res", o_res, exp_q[0]);
      check("busy_in_out", o_busy, 1);
      check("o_done", o_done, i_res_ready);
      if (i_res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("o_res_idle", o_res, 0);
      check("o_done_idle", o_done, 0);
    end
    if (o_ready) check("ready_busy", o_busy, 1);
    if (o_done) done_cnt++;
  end

  task automatic fill(int n, logic [15:0] a, logic [15:0] b);
    for (int k = 0; k < n; k++) begin
      da[k] = a;
      db[k] = b;
    end
  endtask

  task automatic run_job(int n, logic [15:0] bias, bit gaps, int stall, bit poke, output logic [15:0] res);
    int t, k, lim, d0;
    lim = 0;
    while (o_busy && lim < 200) begin
      @(posedge i_clk); #1;
      lim++;
    end
    i_start = 1; i_len = LEN_W'(n); i_bias = bias;
    @(negedge i_clk); t = cyc;
    @(posedge i_clk); #1;
    i_start = 0;
    exp_q.push_back(model(bias, n));
    k = 0; lim = 0;
    while (k < n && lim < 5000) begin
      i_valid = gaps ? (lim % 2 == 1) : 1'b1;
      i_a = da[k]; i_b = db[k];
      if (poke && k == 1) begin i_start = 1; i_len = 1; end
      @(negedge i_clk);
      if (i_valid && o_ready) begin t = cyc; k++; end
      @(posedge i_clk); #1;
      i_valid = 0; i_start = 0;
      lim++;
    end
    check("accepts", k, n);
    lim = 0;
    do begin
      @(negedge i_clk);
      lim++;
    end while (!o_valid && lim < 50);
    check("valid_seen", o_valid, 1);
    check("latency", cyc - t, (n == 0) ? 1 : 2);
    res = o_res;
    d0 = done_cnt;
    repeat (stall) @(negedge i_clk);
    check("res_stable", o_res, res);
    @(posedge i_clk); #1;
    i_res_ready = 1;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_res_ready = 0;
    check("done_once", done_cnt - d0, 1);
    check("idle_after", o_busy, 0);
  endtask

  initial begin
    #2;
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_res", o_res, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;

    fill(3, 16'h2000, 16'h2000);
    check("model_t1", model(16'h1000, 3), 16'h4000);
    run_job(3, 16'h1000, 0, 0, 1, r);
    check("t1_res", r, 16'h4000);

    fill(4, 16'h4000, 16'h2000);
`ifdef MAC_SAT_EN
    check("model_t2", model(16'h0000, 4), 16'h7FFF);
    run_job(4, 16'h0000, 0, 1, 0, r);
    check("t2_res", r, 16'h7FFF);
`else
    check("model_t2", model(16'h0000, 4), 16'h8000);
    run_job(4, 16'h0000, 0, 1, 0, r);
    check("t2_res", r, 16'h8000);
`endif

    fill(2, 16'hC000, 16'h0001);
    check("model_t3", model(16'h0000, 2), 16'hFFFE);
    run_job(2, 16'h0000, 0, 0, 0, r);
    check("t3_res", r, 16'hFFFE);

    run_job(0, 16'hC000, 0, 0, 0, r);
    check("t4_res", r, 16'hC000);

    fill(3, 16'h2000, 16'h2000);
    run_job(3, 16'h1000, 1, 5, 0, r);
    check("t5_res", r, 16'h4000);

    fill(4, 16'h2000, 16'h2000);
    i_start = 1; i_len = 4; i_bias = 16'h0000;
    @(posedge i_clk); #1;
    i_start = 0; i_valid = 1; i_a = 16'h2000; i_b = 16'h2000;
    repeat (2) begin @(posedge i_clk); #1; end
    i_valid = 0;
    i_rst = 1;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_ready", o_ready, 0);
    check("abort_valid", o_valid, 0);
    check("abort_res", o_res, 0);
    check("abort_done", o_done, 0);
    @(posedge i_clk); #1;
    i_rst = 0;
    fill(3, 16'h2000, 16'h2000);
    run_job(3, 16'h1000, 0, 0, 0, r);
    check("t6_res", r, 16'h4000);

    for (int j = 0; j < 30; j++) begin
      int n;
      n = (j == 29) ? 1023 : int'($urandom_range(0, 20));
      for (int k = 0; k < n; k++) begin
        da[k] = (j == 29) ? 16'h8000 : 16'($urandom);
        db[k] = (j == 29) ? 16'h8000 : 16'($urandom);
      end
      run_job(n, 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), r);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
